// File: rtl/data_mem_responder.sv
// Syn/ack data-memory responder: a DEPTH-word RAM that answers one access per
// handshake after WAIT_CYCLES wait states, with a single-cycle ack.
module data_mem_responder #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 32,
  parameter int DEPTH       = 36,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              dm_clk,
  input  logic              dm_rst,
  input  logic              dm_i_syn,
  input  logic              dm_i_we,
  input  logic [AWIDTH-1:0] dm_i_addr,
  input  logic [3:0]        dm_i_be,
  input  logic [DWIDTH-1:0] dm_i_wdata,
  output logic [DWIDTH-1:0] dm_o_rdata,
  output logic              dm_o_ack,
  output logic              dm_o_err,
  output logic              dm_o_busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [AWIDTH-3:0] DEPTH_W = (AWIDTH-2)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];

  logic [AWIDTH-1:0] src_addr;
  logic              src_we;
  logic [AWIDTH-3:0] src_idx;
  logic              src_bad;
  logic [DWIDTH-1:0] src_rdata;
  logic [AWIDTH-3:0] commit_idx;

  // Response is computed on entry to RESP; in IDLE (zero wait states) the
  // request has not been latched yet, so it is taken straight from the inputs.
  always_comb begin
    src_addr  = (state_q == ST_IDLE) ? dm_i_addr : addr_q;
    src_we    = (state_q == ST_IDLE) ? dm_i_we   : we_q;
    src_idx   = src_addr[AWIDTH-1:2];
    src_bad   = (src_addr[1:0] != 2'b00) || (src_idx >= DEPTH_W);
    src_rdata = '0;
    if (!src_bad && !src_we) begin
      src_rdata = mem_q[src_idx[IW-1:0]];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (dm_i_syn) begin
          addr_d  = dm_i_addr;
          we_d    = dm_i_we;
          be_d    = dm_i_be;
          wdata_d = dm_i_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            rdata_d = src_rdata;
            err_d   = src_bad;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          rdata_d = src_rdata;
          err_d   = src_bad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_RELEASE;
      default: begin
        if (!dm_i_syn) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Store lands on the edge leaving RESP, using only the latched request.
  always_comb begin
    commit_idx = addr_q[AWIDTH-1:2];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if ((state_q == ST_RESP) && we_q && !err_q) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (be_q[n]) begin
          mem_d[commit_idx[IW-1:0]][8*n +: 8] = wdata_q[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge dm_clk or posedge dm_rst) begin
    if (dm_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign dm_o_ack   = (state_q == ST_RESP);
  assign dm_o_err   = dm_o_ack && err_q;
  assign dm_o_rdata = rdata_q;
  assign dm_o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances with 0, 1 and 3
// wait states, table-driven accesses plus reset / held-syn / pulsed-syn sequences.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        syn   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [3:0]  be    [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];

  always #5 clk = ~clk;

  data_mem_responder #(.DWIDTH(32), .AWIDTH(32), .DEPTH(36), .WAIT_CYCLES(0)) u_w0 (
    .dm_clk(clk), .dm_rst(rst), .dm_i_syn(syn[0]), .dm_i_we(we[0]), .dm_i_addr(addr[0]),
    .dm_i_be(be[0]), .dm_i_wdata(wdata[0]), .dm_o_rdata(rdata[0]), .dm_o_ack(ack[0]),
    .dm_o_err(err[0]), .dm_o_busy(busy[0]));

  data_mem_responder #(.DWIDTH(32), .AWIDTH(32), .DEPTH(36), .WAIT_CYCLES(1)) u_w1 (
    .dm_clk(clk), .dm_rst(rst), .dm_i_syn(syn[1]), .dm_i_we(we[1]), .dm_i_addr(addr[1]),
    .dm_i_be(be[1]), .dm_i_wdata(wdata[1]), .dm_o_rdata(rdata[1]), .dm_o_ack(ack[1]),
    .dm_o_err(err[1]), .dm_o_busy(busy[1]));

  data_mem_responder #(.DWIDTH(32), .AWIDTH(32), .DEPTH(36), .WAIT_CYCLES(3)) u_w3 (
    .dm_clk(clk), .dm_rst(rst), .dm_i_syn(syn[2]), .dm_i_we(we[2]), .dm_i_addr(addr[2]),
    .dm_i_be(be[2]), .dm_i_wdata(wdata[2]), .dm_o_rdata(rdata[2]), .dm_o_ack(ack[2]),
    .dm_o_err(err[2]), .dm_o_busy(busy[2]));

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One handshake on instance k; syn stays high for `hold` cycles after the
  // sampling edge, and request fields are scrambled once the request is taken.
  task automatic run_access(input int k, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d, input int hold,
                            input logic eerr, input logic [31:0] erd);
    exp_t e;
    exp_t got;
    int   acks = 0;
    int   busy_bad = 0;
    int   err_bad = 0;
    @(negedge clk);
    syn[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    e.err = eerr; e.rdata = erd; e.lat = 1 + wait_of(k);
    sb.push_back(e);
    @(posedge clk);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (ack[k]) begin
        acks++;
        if (acks == 1 && sb.size() > 0) begin
          got = sb.pop_front();
          check($sformatf("k%0d_latency", k), c, got.lat);
          check($sformatf("k%0d_err", k), {31'b0, err[k]}, {31'b0, got.err});
          check($sformatf("k%0d_rdata", k), rdata[k], got.rdata);
        end
      end else if (err[k]) begin
        err_bad++;
      end
      if (c <= hold + 1 && !busy[k]) busy_bad++;
      if (c == 1) begin
        we[k] = $urandom_range(0, 1); addr[k] = $urandom; be[k] = 4'($urandom); wdata[k] = $urandom;
      end
      if (c >= hold + 1) syn[k] = 1'b0;
    end
    if (sb.size() > 0) void'(sb.pop_front());
    check($sformatf("k%0d_ack_count", k), acks, 1);
    check($sformatf("k%0d_busy_while_held", k), busy_bad, 0);
    check($sformatf("k%0d_err_outside_ack", k), err_bad, 0);
    check($sformatf("k%0d_busy_idle", k), {31'b0, busy[k]}, 32'd0);
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0,  1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10, 4'hF, 32'h0,        0,  1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h10, 4'h5, 32'h11223344, 0,  1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h10, 4'h0, 32'h0,        0,  1'b0, 32'hDE22BE44};
    vecs[4]  = '{1'b0, 32'h12, 4'hF, 32'h0,        0,  1'b1, 32'h0};
    vecs[5]  = '{1'b1, 32'h90, 4'hF, 32'hCAFEF00D, 0,  1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h10, 4'hF, 32'h0,        0,  1'b0, 32'hDE22BE44};
    vecs[7]  = '{1'b1, 32'h8C, 4'hF, 32'hA5A5A5A5, 0,  1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h8C, 4'hF, 32'h0,        0,  1'b0, 32'hA5A5A5A5};
    vecs[9]  = '{1'b0, 32'h90, 4'hF, 32'h0,        0,  1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'h11, 4'hF, 32'hFFFFFFFF, 0,  1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h0,  4'hF, 32'h0,        0,  1'b0, 32'h0};
    vecs[12] = '{1'b1, 32'h20, 4'hF, 32'h01020304, 10, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h20, 4'hF, 32'h0,        10, 1'b0, 32'h01020304};
    vecs[14] = '{1'b0, 32'h10, 4'hF, 32'h0,        0,  1'b0, 32'hDE22BE44};

    for (int k = 0; k < 3; k++) begin
      syn[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; be[k] = '0; wdata[k] = '0;
    end

    #12;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("k%0d_reset_out", k), {rdata[k][31:3], ack[k], err[k], busy[k]} | {29'b0, 3'b0}, 32'd0);
      check($sformatf("k%0d_reset_rdata", k), rdata[k], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_access(1, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].hold,
                 vecs[i].exp_err, vecs[i].exp_rdata);
    end

    // Zero wait states.
    run_access(0, 1'b1, 32'h4,  4'hF, 32'h12345678, 0,  1'b0, 32'h0);
    run_access(0, 1'b0, 32'h4,  4'hF, 32'h0,        10, 1'b0, 32'h12345678);
    run_access(0, 1'b1, 32'h4,  4'hA, 32'hAABBCCDD, 0,  1'b0, 32'h0);
    run_access(0, 1'b0, 32'h4,  4'h0, 32'h0,        0,  1'b0, 32'hAA34CC78);
    run_access(0, 1'b0, 32'h88, 4'h0, 32'h0,        0,  1'b0, 32'h0);

    // Three wait states.
    run_access(2, 1'b1, 32'h4, 4'hF, 32'h0BADF00D, 0, 1'b0, 32'h0);
    run_access(2, 1'b0, 32'h4, 4'hF, 32'h0,        0, 1'b0, 32'h0BADF00D);
    run_access(2, 1'b1, 32'h7, 4'hF, 32'h11111111, 0, 1'b1, 32'h0);
    run_access(2, 1'b0, 32'h4, 4'hF, 32'h0,        3, 1'b0, 32'h0BADF00D);

    // Reset in the middle of a store's wait state.
    @(negedge clk);
    syn[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8; be[1] = 4'hF; wdata[1] = 32'h55AA55AA;
    @(posedge clk);
    #2;
    syn[1] = 1'b0;
    check("busy_before_reset", {31'b0, busy[1]}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_reset_ack", {31'b0, ack[1]}, 32'd0);
    check("mid_reset_err", {31'b0, err[1]}, 32'd0);
    check("mid_reset_busy", {31'b0, busy[1]}, 32'd0);
    check("mid_reset_rdata", rdata[1], 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_access(1, 1'b0, 32'h8,  4'hF, 32'h0, 0, 1'b0, 32'h0);
    run_access(1, 1'b0, 32'h10, 4'hF, 32'h0, 0, 1'b0, 32'h0);
    run_access(0, 1'b0, 32'h4,  4'hF, 32'h0, 0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
